cur_addr_gen: RTL and testbench

- Upstream address/control sequencer for the current-block RAM stage. It sweeps one CU inside a 128x128 CTU in 4x4 sub-blocks, raster order.
- For each sub-block it issues four row word-addresses plus the en / export_data_cur strobes the RAM stage needs. It also flags when the 4x4 current data is valid on that stage's outputs.
- Sits between the affine CU controller and the current-data RAM. It feeds the SAD/residual stage its sub-block timing.

---
 rtl/cur_addr_gen.sv | 217 +++++++++++++++++++++
 tb/tb_cur_addr_gen.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cur_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : cur_addr_gen
//  Description : Sweeps one CU of a 128x128 CTU in 4x4 sub-blocks (raster
//                order). For each sub-block it issues four row word-addresses
//                and the en / export_data_cur strobes for the current-block
//                RAM. It also flags when the 4x4 data is valid downstream.
//  Revision    : 1.0 - initial release
// ============================================================================
module cur_addr_gen #(
    parameter int CTU_SIZE      = 128,
    parameter int PIX_PER_WORD  = 4,
    parameter int WORDS_PER_ROW = 32,
    parameter int ADDR_W        = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              ram_busy,
    input  logic [6:0]        cu_x,
    input  logic [6:0]        cu_y,
    input  logic [7:0]        cu_w,
    input  logic [7:0]        cu_h,
    input  logic              ready,
    output logic              en,
    output logic              export_data_cur,
    output logic [ADDR_W-1:0] cur_addr0,
    output logic [ADDR_W-1:0] cur_addr1,
    output logic [ADDR_W-1:0] cur_addr2,
    output logic [ADDR_W-1:0] cur_addr3,
    output logic              blk_valid,
    output logic [4:0]        blk_bx,
    output logic [4:0]        blk_by,
    output logic              last_blk,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [8:0]        c_ctu    = 9'(CTU_SIZE);
    localparam logic [ADDR_W-1:0] c_stride = ADDR_W'(WORDS_PER_ROW);
    localparam int                c_al     = $clog2(PIX_PER_WORD);

    logic [1:0]        r_state;
    logic [1:0]        r_cnt;
    logic [4:0]        r_col0;
    logic [6:0]        r_cu_y;
    logic [4:0]        r_bx_last;
    logic [4:0]        r_by_last;
    logic [4:0]        r_bx;
    logic [4:0]        r_by;
    logic              r_en;
    logic              r_exp;
    logic [ADDR_W-1:0] r_addr [4];
    logic [4:0]        r_iss_bx;
    logic [4:0]        r_iss_by;
    logic              r_iss_last;
    logic [4:0]        r_p1_bx;
    logic [4:0]        r_p1_by;
    logic              r_p1_last;
    logic              r_blk_valid;
    logic [4:0]        r_blk_bx;
    logic [4:0]        r_blk_by;
    logic              r_blk_last;
    logic              r_busy;
    logic              r_done;
    logic              r_cfg_err;

    logic [8:0]        w_x_end;
    logic [8:0]        w_y_end;
    logic              w_cfg_ok;
    logic              w_last;
    logic [4:0]        w_col;
    logic [7:0]        w_row  [4];
    logic [ADDR_W-1:0] w_addr [4];

    // Configuration check and next sub-block address computation
    always_comb begin
        w_x_end  = {2'b00, cu_x} + {1'b0, cu_w};
        w_y_end  = {2'b00, cu_y} + {1'b0, cu_h};
        w_cfg_ok = (cu_w != 8'd0) && (cu_h != 8'd0) &&
                   (cu_w[c_al-1:0] == '0) && (cu_h[c_al-1:0] == '0) &&
                   ({1'b0, cu_w} <= c_ctu) && ({1'b0, cu_h} <= c_ctu) &&
                   (w_x_end <= c_ctu) && (w_y_end <= c_ctu);
        w_last   = (r_bx == r_bx_last) && (r_by == r_by_last);
        // Sub-block column in RAM words: one word holds exactly one 4-pixel row
        w_col    = r_col0 + r_bx;
        for (int r = 0; r < 4; r++) begin
            w_row[r]  = {1'b0, r_cu_y} + {1'b0, r_by, 2'b00} + 8'(r);
            w_addr[r] = {{(ADDR_W-8){1'b0}}, w_row[r]} * c_stride +
                        {{(ADDR_W-5){1'b0}}, w_col};
        end
    end

    // Sweep FSM, issue strobes and the two-stage valid/index pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 2'd0;
            r_col0      <= 5'd0;
            r_cu_y      <= 7'd0;
            r_bx_last   <= 5'd0;
            r_by_last   <= 5'd0;
            r_bx        <= 5'd0;
            r_by        <= 5'd0;
            r_en        <= 1'b0;
            r_exp       <= 1'b0;
            for (int r = 0; r < 4; r++) r_addr[r] <= '0;
            r_iss_bx    <= 5'd0;
            r_iss_by    <= 5'd0;
            r_iss_last  <= 1'b0;
            r_p1_bx     <= 5'd0;
            r_p1_by     <= 5'd0;
            r_p1_last   <= 1'b0;
            r_blk_valid <= 1'b0;
            r_blk_bx    <= 5'd0;
            r_blk_by    <= 5'd0;
            r_blk_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_en        <= 1'b0;
            r_iss_last  <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_err   <= 1'b0;

            // RAM output register loads one cycle after the read, data is
            // usable one cycle after that
            r_exp       <= r_en;
            r_p1_bx     <= r_iss_bx;
            r_p1_by     <= r_iss_by;
            r_p1_last   <= r_iss_last;
            r_blk_valid <= r_exp;
            r_blk_bx    <= r_p1_bx;
            r_blk_by    <= r_p1_by;
            r_blk_last  <= r_p1_last;

            case (r_state)
                S_IDLE: begin
                    if (start && !ram_busy) begin
                        if (w_cfg_ok) begin
                            r_col0    <= cu_x[6:2];
                            r_cu_y    <= cu_y;
                            r_bx_last <= 5'(cu_w[7:2] - 6'd1);
                            r_by_last <= 5'(cu_h[7:2] - 6'd1);
                            r_bx      <= 5'd0;
                            r_by      <= 5'd0;
                            r_busy    <= 1'b1;
                            r_state   <= S_RUN;
                        end else begin
                            r_cfg_err <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (ready && !ram_busy) begin
                        r_en       <= 1'b1;
                        for (int r = 0; r < 4; r++) r_addr[r] <= w_addr[r];
                        r_iss_bx   <= r_bx;
                        r_iss_by   <= r_by;
                        r_iss_last <= w_last;
                        if (r_bx == r_bx_last) begin
                            r_bx <= 5'd0;
                            if (r_by == r_by_last) begin
                                r_cnt   <= 2'd0;
                                r_state <= S_DRAIN;
                            end else begin
                                r_by <= r_by + 5'd1;
                            end
                        end else begin
                            r_bx <= r_bx + 5'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    // Holds until the final block has left the pipeline
                    if (r_cnt == 2'd2) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign en              = r_en;
    assign export_data_cur = r_exp;
    assign cur_addr0       = r_addr[0];
    assign cur_addr1       = r_addr[1];
    assign cur_addr2       = r_addr[2];
    assign cur_addr3       = r_addr[3];
    assign blk_valid       = r_blk_valid;
    assign blk_bx          = r_blk_bx;
    assign blk_by          = r_blk_by;
    assign last_blk        = r_blk_last;
    assign busy            = r_busy;
    assign done            = r_done;
    assign cfg_err         = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_cur_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cur_addr_gen
//  Description : Self-checking bench for cur_addr_gen. Expected addresses and
//                block indices come from the CU geometry with plain arithmetic;
//                timing expectations follow the issue/valid latency rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cur_addr_gen;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        ram_busy;
    logic [6:0]  cu_x;
    logic [6:0]  cu_y;
    logic [7:0]  cu_w;
    logic [7:0]  cu_h;
    logic        ready;
    logic        en;
    logic        export_data_cur;
    logic [12:0] cur_addr0;
    logic [12:0] cur_addr1;
    logic [12:0] cur_addr2;
    logic [12:0] cur_addr3;
    logic        blk_valid;
    logic [4:0]  blk_bx;
    logic [4:0]  blk_by;
    logic        last_blk;
    logic        busy;
    logic        done;
    logic        cfg_err;

    int compared;
    int mismatched;
    int last_addr [4];

    cur_addr_gen dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .ram_busy        (ram_busy),
        .cu_x            (cu_x),
        .cu_y            (cu_y),
        .cu_w            (cu_w),
        .cu_h            (cu_h),
        .ready           (ready),
        .en              (en),
        .export_data_cur (export_data_cur),
        .cur_addr0       (cur_addr0),
        .cur_addr1       (cur_addr1),
        .cur_addr2       (cur_addr2),
        .cur_addr3       (cur_addr3),
        .blk_valid       (blk_valid),
        .blk_bx          (blk_bx),
        .blk_by          (blk_by),
        .last_blk        (last_blk),
        .busy            (busy),
        .done            (done),
        .cfg_err         (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Word address of row r of the j-th sub-block in raster order
    function automatic int exp_addr(input int x, input int y, input int w,
                                    input int j, input int r);
        int nw;
        nw = w / 4;
        return (y + 4 * (j / nw) + r) * 32 + x / 4 + (j % nw);
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, ".en"},   int'(en), 0);
        chk({tag, ".exp"},  int'(export_data_cur), 0);
        chk({tag, ".a0"},   int'(cur_addr0), 0);
        chk({tag, ".a3"},   int'(cur_addr3), 0);
        chk({tag, ".bv"},   int'(blk_valid), 0);
        chk({tag, ".bx"},   int'(blk_bx), 0);
        chk({tag, ".by"},   int'(blk_by), 0);
        chk({tag, ".last"}, int'(last_blk), 0);
        chk({tag, ".busy"}, int'(busy), 0);
        chk({tag, ".done"}, int'(done), 0);
        chk({tag, ".cerr"}, int'(cfg_err), 0);
    endtask

    // mode 0: ready always high
    // mode 1: ready low on cycles 2..4 after start
    // mode 2: random ready and ram_busy
    // mode 3: ready high, a second start with another config mid-sweep
    task automatic sweep(input int x, input int y, input int w, input int h,
                         input int mode);
        int  n;
        int  issued;
        int  p1;
        int  p2;
        int  cur;
        bit  r;
        bit  b;
        bit  en_e;
        bit  last_prev;
        bit  after_done;
        bit  finished;
        n          = (w / 4) * (h / 4);
        issued     = 0;
        p1         = -1;
        p2         = -1;
        last_prev  = 1'b0;
        after_done = 1'b0;
        finished   = 1'b0;

        cu_x = 7'(x); cu_y = 7'(y); cu_w = 8'(w); cu_h = 8'(h);
        ram_busy = 1'b0; ready = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("sw.busy0", int'(busy), 1);
        chk("sw.en0",   int'(en), 0);

        for (int cyc = 1; cyc < 3000 && !finished; cyc++) begin
            case (mode)
                1:       begin r = !(cyc >= 2 && cyc <= 4); b = 1'b0; end
                2:       begin r = ($urandom_range(0, 3) != 0); b = ($urandom_range(0, 4) == 0); end
                default: begin r = 1'b1; b = 1'b0; end
            endcase
            if (mode == 3 && cyc == 3) begin
                start = 1'b1; cu_x = 7'd0; cu_y = 7'd0; cu_w = 8'd128; cu_h = 8'd128;
            end
            ready = r; ram_busy = b;
            @(posedge clk); #1;
            start = 1'b0; cu_x = 7'(x); cu_y = 7'(y); cu_w = 8'(w); cu_h = 8'(h);

            en_e = r && !b && (issued < n);
            cur  = -1;
            if (en_e) begin
                for (int k = 0; k < 4; k++) last_addr[k] = exp_addr(x, y, w, issued, k);
                cur = issued;
                issued++;
            end
            chk("sw.en",   int'(en), int'(en_e));
            chk("sw.a0",   int'(cur_addr0), last_addr[0]);
            chk("sw.a1",   int'(cur_addr1), last_addr[1]);
            chk("sw.a2",   int'(cur_addr2), last_addr[2]);
            chk("sw.a3",   int'(cur_addr3), last_addr[3]);
            chk("sw.exp",  int'(export_data_cur), int'(p1 >= 0));
            chk("sw.bv",   int'(blk_valid), int'(p2 >= 0));
            chk("sw.last", int'(last_blk), int'(p2 == n - 1));
            if (p2 >= 0) begin
                chk("sw.bx", int'(blk_bx), p2 % (w / 4));
                chk("sw.by", int'(blk_by), p2 / (w / 4));
            end
            chk("sw.done", int'(done), int'(last_prev));
            chk("sw.busy", int'(busy), int'(!after_done));
            if (after_done) finished = 1'b1;
            after_done = after_done | last_prev;
            last_prev  = (p2 == n - 1);
            p2 = p1;
            p1 = cur;
        end
        if (!finished) chk("sw.timeout", 0, 1);
        chk("sw.count", issued, n);
        ready = 1'b0; ram_busy = 1'b0;
    endtask

    initial begin
        int rw;
        int rh;
        int rx;
        int ry;
        compared   = 0;
        mismatched = 0;
        for (int k = 0; k < 4; k++) last_addr[k] = 0;
        rst_n = 1'b0; start = 1'b0; ram_busy = 1'b0; ready = 1'b0;
        cu_x = 7'd0; cu_y = 7'd0; cu_w = 8'd0; cu_h = 8'd0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 8x8 CU at (16,8), ready held high
        sweep(16, 8, 8, 8, 0);
        chk("8x8.lastA0", int'(cur_addr0), 389);
        chk("8x8.lastA3", int'(cur_addr3), 485);

        // Full 128x128 CU
        sweep(0, 0, 128, 128, 0);
        chk("128.lastA0", int'(cur_addr0), 3999);
        chk("128.lastA3", int'(cur_addr3), 4095);

        // Same 8x8 CU with a stall
        sweep(16, 8, 8, 8, 1);

        // Single 4x4 CU at the far corner
        sweep(124, 124, 4, 4, 0);

        // Out-of-range config is rejected
        cu_x = 7'd124; cu_y = 7'd0; cu_w = 8'd8; cu_h = 8'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("cerr.pulse", int'(cfg_err), 1);
        chk("cerr.busy",  int'(busy), 0);
        @(posedge clk); #1;
        chk("cerr.clear", int'(cfg_err), 0);
        chk("cerr.busy2", int'(busy), 0);

        // Start while RAM is loading is ignored
        cu_x = 7'd0; cu_w = 8'd8; ram_busy = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("rb.busy", int'(busy), 0);
        chk("rb.cerr", int'(cfg_err), 0);
        ram_busy = 1'b0;
        @(posedge clk); #1;
        chk("rb.busy2", int'(busy), 0);
        chk("rb.en",    int'(en), 0);

        // Second start mid-sweep is ignored
        sweep(16, 8, 8, 8, 3);

        // Randomized geometry with random ready / ram_busy
        for (int t = 0; t < 6; t++) begin
            rw = 4 * $urandom_range(1, 8);
            rh = 4 * $urandom_range(1, 8);
            rx = 4 * $urandom_range(0, (128 - rw) / 4);
            ry = 4 * $urandom_range(0, (128 - rh) / 4);
            sweep(rx, ry, rw, rh, 2);
        end

        // Asynchronous reset mid-sweep
        cu_x = 7'd16; cu_y = 7'd16; cu_w = 8'd32; cu_h = 8'd32; start = 1'b1; ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all_zero("arst");
        for (int k = 0; k < 4; k++) last_addr[k] = 0;
        @(posedge clk); #1;
        chk("arst.done", int'(done), 0);
        ready = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst.idle", int'(busy), 0);

        // Clean sweep after reset
        sweep(16, 8, 8, 8, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
